// File: rtl/name_initial_scroller.sv
// Multiplexed seven-segment message display with static or scrolling window.
// Latency: registered outputs; a write or offset change shows on the next edge.
// Backpressure: none; writes are always accepted, out-of-range slots are dropped.
module name_initial_scroller #(
  parameter int NUM_DIGITS     = 4,
  parameter int MSG_LEN        = 8,
  parameter int REFRESH_DIV    = 50000,
  parameter int SCROLL_DIV     = 25000000,
  parameter int SEG_ACTIVE_LOW = 1,
  localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [4:0]            wr_char,
  input  logic                  mode,
  input  logic                  run,
  output logic [0:6]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  wrap
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [6:0] BLANK_SEG = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  // Lit-high glyphs, bit 6 = segment a ... bit 0 = segment g.
  function automatic logic [6:0] glyph(input logic [4:0] code);
    logic [6:0] g;
    case (code)
      5'd1:    g = 7'b1110111; // A
      5'd2:    g = 7'b1111111; // B
      5'd3:    g = 7'b1001110; // C
      5'd4:    g = 7'b0111101; // D
      5'd5:    g = 7'b1001111; // E
      5'd6:    g = 7'b1000111; // F
      5'd7:    g = 7'b1011110; // G
      5'd8:    g = 7'b0110111; // H
      5'd9:    g = 7'b0110000; // I
      5'd10:   g = 7'b0111000; // J
      5'd11:   g = 7'b1010111; // K
      5'd12:   g = 7'b0001110; // L
      5'd13:   g = 7'b1110110; // M
      5'd14:   g = 7'b0010101; // N
      5'd15:   g = 7'b1111110; // O
      5'd16:   g = 7'b1100111; // P
      5'd17:   g = 7'b1110011; // Q
      5'd18:   g = 7'b0000101; // R
      5'd19:   g = 7'b1011011; // S
      5'd20:   g = 7'b0001111; // T
      5'd21:   g = 7'b0111110; // U
      5'd22:   g = 7'b0011100; // V
      5'd23:   g = 7'b0101010; // W
      5'd24:   g = 7'b0110111; // X
      5'd25:   g = 7'b0111011; // Y
      5'd26:   g = 7'b1101101; // Z
      default: g = 7'b0000000; // 0 and 27..31 are blank
    endcase
    return g;
  endfunction

  logic [4:0]            msg [MSG_LEN];
  logic [RW-1:0]         rcnt;
  logic [IW-1:0]         idx;
  logic [AW-1:0]         offset;
  logic [SW-1:0]         psc;
  logic                  fresh;      // first cycle of a new dwell: blank it
  logic                  wrap_pend;  // offset just wrapped; pulse wrap next edge
  logic                  refresh_tc;
  logic                  scroll_tc;
  logic                  offset_last;
  logic [AW-1:0]         slot;
  logic [6:0]            cur_glyph;
  logic [NUM_DIGITS-1:0] an_next;
  int unsigned           slot_sum;

  assign refresh_tc  = (rcnt == RW'(REFRESH_DIV - 1));
  assign scroll_tc   = (psc == SW'(SCROLL_DIV - 1));
  assign offset_last = (int'(offset) == MSG_LEN - 1);

  // Message register file: cleared on reset, in-range writes only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MSG_LEN; i++) msg[i] <= '0;
    end else if (wr_en && (int'(wr_addr) < MSG_LEN)) begin
      msg[wr_addr] <= wr_char;
    end
  end

  // Refresh dwell counter and active digit index; flag the start of each new dwell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt  <= '0;
      idx   <= '0;
      fresh <= 1'b0;
    end else if (refresh_tc) begin
      rcnt  <= '0;
      idx   <= (int'(idx) == NUM_DIGITS - 1) ? '0 : idx + IW'(1);
      fresh <= 1'b1;
    end else begin
      rcnt  <= rcnt + RW'(1);
      fresh <= 1'b0;
    end
  end

  // Scroll prescaler and window offset; static mode parks both at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc       <= '0;
      offset    <= '0;
      wrap_pend <= 1'b0;
    end else begin
      wrap_pend <= mode && run && scroll_tc && offset_last;
      if (!mode) begin
        psc    <= '0;
        offset <= '0;
      end else if (run) begin
        if (scroll_tc) begin
          psc    <= '0;
          offset <= offset_last ? '0 : offset + AW'(1);
        end else begin
          psc    <= psc + SW'(1);
        end
      end
    end
  end

  // Look up the character for the active digit and build its one-hot select.
  always_comb begin
    slot_sum  = 32'(offset) + 32'(idx);
    slot      = AW'(slot_sum % MSG_LEN);
    cur_glyph = glyph(msg[slot]);
    an_next   = ~(NUM_DIGITS'(1) << idx);
  end

  // Registered pin drivers; the first cycle of a dwell is dark to avoid ghosting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an   <= '1;
      seg  <= BLANK_SEG;
      wrap <= 1'b0;
    end else begin
      wrap <= wrap_pend;
      if (fresh) begin
        an  <= '1;
        seg <= BLANK_SEG;
      end else begin
        an  <= an_next;
        seg <= (SEG_ACTIVE_LOW != 0) ? ~cur_glyph : cur_glyph;
      end
    end
  end

endmodule

// File: tb/tb_name_initial_scroller.sv
// Directed bench: reset, static scan table, scroll/wrap, hold/clear, async reset.
// Three builds: main (active-low), positive-polarity MSG_LEN=9, and MSG_LEN=1.
// Inputs driven 1 ns after the rising edge, outputs sampled at the same point.
module tb_name_initial_scroller;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n;

  // main build
  logic       wr_en, mode, run;
  logic [2:0] wr_addr;
  logic [4:0] wr_char;
  logic [0:6] seg;
  logic [3:0] an;
  logic       wrap;

  // positive-polarity, 9-slot build
  logic       p_wr_en, p_mode, p_run;
  logic [3:0] p_wr_addr;
  logic [4:0] p_wr_char;
  logic [0:6] p_seg;
  logic [3:0] p_an;
  logic       p_wrap;

  // single-slot build
  logic       o_wr_en, o_mode, o_run;
  logic [0:0] o_wr_addr;
  logic [4:0] o_wr_char;
  logic [0:6] o_seg;
  logic [1:0] o_an;
  logic       o_wrap;

  name_initial_scroller #(.NUM_DIGITS(4), .MSG_LEN(8), .REFRESH_DIV(4), .SCROLL_DIV(64),
                          .SEG_ACTIVE_LOW(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
    .mode(mode), .run(run), .seg(seg), .an(an), .wrap(wrap));

  name_initial_scroller #(.NUM_DIGITS(4), .MSG_LEN(9), .REFRESH_DIV(4), .SCROLL_DIV(64),
                          .SEG_ACTIVE_LOW(0)) u_pos (
    .clk(clk), .rst_n(rst_n), .wr_en(p_wr_en), .wr_addr(p_wr_addr), .wr_char(p_wr_char),
    .mode(p_mode), .run(p_run), .seg(p_seg), .an(p_an), .wrap(p_wrap));

  name_initial_scroller #(.NUM_DIGITS(2), .MSG_LEN(1), .REFRESH_DIV(2), .SCROLL_DIV(4),
                          .SEG_ACTIVE_LOW(1)) u_one (
    .clk(clk), .rst_n(rst_n), .wr_en(o_wr_en), .wr_addr(o_wr_addr), .wr_char(o_wr_char),
    .mode(o_mode), .run(o_run), .seg(o_seg), .an(o_an), .wrap(o_wrap));

  always #5 clk = clk_en ? ~clk : 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  int n = 0;          // rising edges since the last reset release
  bit one_chk = 1'b0; // check the single-slot build's wrap train
  int wraps = 0;
  int msg_m [8] = '{6, 2, 1, 0, 0, 0, 0, 0};

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic [3:0] p_an;
    logic [6:0] p_seg;
  } vec_t;
  vec_t tbl [16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0b, expected %0b", nm, n, act, exp);
    end
  endtask

  function automatic logic [6:0] tb_glyph(input int c);
    case (c)
      1:       return 7'b1110111;
      2:       return 7'b1111111;
      3:       return 7'b1001110;
      6:       return 7'b1000111;
      default: return 7'b0000000;
    endcase
  endfunction

  // Digit shown after edge e (-1 = dark); first dwell has no dark cycle.
  function automatic int digit_at(input int e);
    int m;
    if (e <= 4) return 0;
    m = e - 5;
    if (m % 4 == 0) return -1;
    return ((m / 4) + 1) % 4;
  endfunction

  // Offset in force before edge e, derived from the stimulus schedule below.
  function automatic int exp_off(input int e);
    if (e <= 576) return ((e - 35) / 64) % 8;
    if (e <= 818) return 0;
    if (e == 819) return 1;
    if (e <= 834) return 0;
    return ((e - 835) / 64) % 8;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    n = n + 1;
    if (one_chk) begin
      check("one_wrap", o_wrap, (n >= 5) && ((n - 5) % 4 == 0));
      if (n >= 40) one_chk = 1'b0;
    end
  endtask

  task automatic chk_disp(input int off);
    int d;
    logic [3:0] ea;
    logic [6:0] es;
    d = digit_at(n);
    if (d < 0) begin
      ea = 4'hF;
      es = 7'h7F;
    end else begin
      ea = ~(4'b0001 << d);
      es = ~tb_glyph(msg_m[(off + d) % 8]);
    end
    check("scan_an", an, ea);
    check("scan_seg", seg, es);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{4'hF,    7'h7F,      4'hF,    7'h00};
    tbl[1]  = '{4'b1101, 7'b0000000, 4'b1101, 7'b0000000};
    tbl[2]  = '{4'b1101, 7'b0000000, 4'b1101, 7'b0000000};
    tbl[3]  = '{4'b1101, 7'b0000000, 4'b1101, 7'b0000000};
    tbl[4]  = '{4'hF,    7'h7F,      4'hF,    7'h00};
    tbl[5]  = '{4'b1011, 7'b0001000, 4'b1011, 7'b1001110};
    tbl[6]  = '{4'b1011, 7'b0001000, 4'b1011, 7'b1001110};
    tbl[7]  = '{4'b1011, 7'b0001000, 4'b1011, 7'b1001110};
    tbl[8]  = '{4'hF,    7'h7F,      4'hF,    7'h00};
    tbl[9]  = '{4'b0111, 7'b1111111, 4'b0111, 7'b0000000};
    tbl[10] = '{4'b0111, 7'b1111111, 4'b0111, 7'b0000000};
    tbl[11] = '{4'b0111, 7'b1111111, 4'b0111, 7'b0000000};
    tbl[12] = '{4'hF,    7'h7F,      4'hF,    7'h00};
    tbl[13] = '{4'b1110, 7'b0111000, 4'b1110, 7'b1000111};
    tbl[14] = '{4'b1110, 7'b0111000, 4'b1110, 7'b1000111};
    tbl[15] = '{4'b1110, 7'b0111000, 4'b1110, 7'b1000111};

    wr_en = 0; wr_addr = 0; wr_char = 0; mode = 0; run = 1;
    p_wr_en = 0; p_wr_addr = 0; p_wr_char = 0; p_mode = 0; p_run = 0;
    o_wr_en = 0; o_wr_addr = 0; o_wr_char = 0; o_mode = 1; o_run = 1;
    rst_n = 1;

    // Reset asserted with the clock stopped.
    #2 rst_n = 0;
    #2;
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_wrap", wrap, 1'b0);
    check("rst_p_seg", p_seg, 7'h00);
    #2 rst_n = 1;
    clk_en = 1;
    one_chk = 1'b1;

    tick(); // edge 1: no dark cycle on the first dwell
    check("rel_an", an, 4'hE);
    check("rel_seg", seg, 7'h7F);
    check("rel_wrap", wrap, 1'b0);
    check("rel_p_an", p_an, 4'hE);
    check("rel_p_seg", p_seg, 7'h00);
    wr_en = 1; wr_addr = 0; wr_char = 6;
    p_wr_en = 1; p_wr_addr = 0; p_wr_char = 6;
    tick(); // edge 2: write lands now, visible next edge
    check("wr_lat_before", seg, 7'h7F);
    wr_addr = 1; wr_char = 2;
    p_wr_addr = 1; p_wr_char = 29;
    tick(); // edge 3
    check("wr_lat_after", seg, 7'b0111000);
    check("pos_F", p_seg, 7'b1000111);
    wr_addr = 2; wr_char = 1;
    p_wr_addr = 2; p_wr_char = 3;
    tick(); // edge 4
    check("dig0_last_an", an, 4'hE);
    check("dig0_last_seg", seg, 7'b0111000);
    wr_en = 0;
    p_wr_addr = 11; p_wr_char = 1; // out of range: must not land anywhere

    // Static scan, edges 5..20.
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 0) p_wr_en = 0;
      check($sformatf("tbl%0d_an", i), an, tbl[i].an);
      check($sformatf("tbl%0d_seg", i), seg, tbl[i].seg);
      check($sformatf("tbl%0d_p_an", i), p_an, tbl[i].p_an);
      check($sformatf("tbl%0d_p_seg", i), p_seg, tbl[i].p_seg);
    end

    // Scroll, wrap, hold, clear, re-scroll up to edge 1163.
    for (int e = 21; e <= 1163; e++) begin
      tick();
      chk_disp(exp_off(n));
      check("wrap", wrap, n == 547);
      if (wrap) wraps++;
      if (n == 98)   check("step1_old_F", seg, 7'b0111000);
      if (n == 99)   check("step1_new_B", seg, 7'b0000000);
      if (n == 546)  check("prewrap_slot7", seg, 7'h7F);
      if (n == 547)  check("postwrap_F", seg, 7'b0111000);
      if (n == 818)  check("resume_old_F", seg, 7'b0111000);
      if (n == 819)  check("resume_new_B", seg, 7'b0000000);
      if (n == 820)  check("mode0_clear_F", seg, 7'b0111000);
      if (n == 1163) check("mid_digit2_an", an, 4'b1011);
      if (n == 34)  mode = 1;
      if (n == 576) run = 0;   // prescaler sits at 30 here
      if (n == 784) run = 1;   // 34 more edges to the next step
      if (n == 818) mode = 0;
      if (n == 834) mode = 1;
    end
    check("wrap_count", wraps, 1);

    // Async reset mid-scroll (offset 5, digit 2 active).
    rst_n = 0;
    #1;
    check("arst_an", an, 4'hF);
    check("arst_seg", seg, 7'h7F);
    check("arst_wrap", wrap, 1'b0);
    check("arst_p_an", p_an, 4'hF);
    check("arst_p_seg", p_seg, 7'h00);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1;
    n = 0;
    wr_en = 1; wr_addr = 0; wr_char = 3;
    tick(); // edge 1
    check("rel2_an", an, 4'hE);
    check("rel2_seg", seg, 7'h7F);
    wr_en = 0;
    tick(); // edge 2: C at slot 0 proves offset restarted at 0
    check("rel2_off0_C", seg, 7'b0110001);
    while (n < 6) tick();
    check("rel2_d1_an", an, 4'b1101);
    check("rel2_slot1_blank", seg, 7'h7F);
    while (n < 10) tick();
    check("rel2_d2_an", an, 4'b1011);
    check("rel2_slot2_blank", seg, 7'h7F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
